// File: rtl/sps_match_ctrl_if.sv
// Bundle of the handshake, judge and score signals around the stone-paper-scissors
// match sequencer. The slave modport is the controller's view; master is the environment's.
interface sps_match_ctrl_if #(
    parameter int unsigned SCORE_W = 4
);
    logic               ena;
    logic               new_match;
    logic [1:0]         p1_move;
    logic               p1_valid;
    logic               p1_ready;
    logic [1:0]         p2_move;
    logic               p2_valid;
    logic               p2_ready;
    logic               jdg_start;
    logic [1:0]         jdg_p1;
    logic [1:0]         jdg_p2;
    logic               jdg_done;
    logic [1:0]         jdg_result;
    logic [SCORE_W-1:0] score1;
    logic [SCORE_W-1:0] score2;
    logic [3:0]         round_cnt;
    logic               match_over;
    logic [1:0]         match_winner;
    logic [1:0]         bad_move;
    logic               err;

    modport slave (
        input  ena, new_match, p1_move, p1_valid, p2_move, p2_valid, jdg_done, jdg_result,
        output p1_ready, p2_ready, jdg_start, jdg_p1, jdg_p2, score1, score2, round_cnt,
               match_over, match_winner, bad_move, err
    );

    modport master (
        output ena, new_match, p1_move, p1_valid, p2_move, p2_valid, jdg_done, jdg_result,
        input  p1_ready, p2_ready, jdg_start, jdg_p1, jdg_p2, score1, score2, round_cnt,
               match_over, match_winner, bad_move, err
    );
endinterface

// File: rtl/sps_match_ctrl.sv
// Best-of-N stone-paper-scissors match sequencer: collects both moves, launches the
// round judge, keeps scores. Define SPS_JUDGE_TIMEOUT_EN to abort a hung judge.
module sps_match_ctrl #(
    parameter int unsigned WIN_TARGET  = 2,
    parameter int unsigned MAX_ROUNDS  = 9,
    parameter int unsigned SCORE_W     = 4,
    parameter int unsigned JDG_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    sps_match_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_JUDGE,
        S_UPDATE,
        S_OVER
    } state_t;

    localparam logic [SCORE_W-1:0] WIN_T = SCORE_W'(WIN_TARGET);
    localparam logic [3:0]         MAX_R = 4'(MAX_ROUNDS);

    if (WIN_TARGET < 1 || WIN_TARGET >= (1 << SCORE_W) || MAX_ROUNDS < 1 ||
        MAX_ROUNDS > 15 || JDG_TIMEOUT < 1) begin : g_cfg_check
        $error("sps_match_ctrl: unsupported parameter set");
    end

    state_t             state_q, state_d;
    logic [1:0]         p1_mv_q, p1_mv_d, p2_mv_q, p2_mv_d;
    logic               p1_have_q, p1_have_d, p2_have_q, p2_have_d;
    logic [1:0]         res_q, res_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;
    logic [3:0]         round_q, round_d;
    logic               over_q, over_d;
    logic [1:0]         winner_q, winner_d;
    logic [1:0]         bad_q, bad_d;
    logic               first_q, first_d;

`ifdef SPS_JUDGE_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(JDG_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(JDG_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    logic p1_rdy, p2_rdy, p1_hs, p2_hs;

    assign p1_rdy = bus.ena && (state_q == S_COLLECT) && !p1_have_q;
    assign p2_rdy = bus.ena && (state_q == S_COLLECT) && !p2_have_q;
    assign p1_hs  = p1_rdy && bus.p1_valid;
    assign p2_hs  = p2_rdy && bus.p2_valid;

    always_comb begin
        state_d   = state_q;
        p1_mv_d   = p1_mv_q;
        p2_mv_d   = p2_mv_q;
        p1_have_d = p1_have_q;
        p2_have_d = p2_have_q;
        res_d     = res_q;
        score1_d  = score1_q;
        score2_d  = score2_q;
        round_d   = round_q;
        over_d    = over_q;
        winner_d  = winner_q;
        bad_d     = 2'b00;
        first_d   = 1'b0;
`ifdef SPS_JUDGE_TIMEOUT_EN
        tmo_d     = tmo_q;
        err_d     = err_q;
`endif
        // A new match wins over everything, including a judge result landing now.
        if (bus.new_match) begin
            state_d   = S_COLLECT;
            p1_mv_d   = 2'b00;
            p2_mv_d   = 2'b00;
            p1_have_d = 1'b0;
            p2_have_d = 1'b0;
            score1_d  = '0;
            score2_d  = '0;
            round_d   = '0;
            over_d    = 1'b0;
            winner_d  = 2'b00;
`ifdef SPS_JUDGE_TIMEOUT_EN
            tmo_d     = '0;
            err_d     = 1'b0;
`endif
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (p1_hs) begin
                        if (bus.p1_move != 2'b11) begin
                            p1_mv_d   = bus.p1_move;
                            p1_have_d = 1'b1;
                        end else begin
                            bad_d[0] = 1'b1;
                        end
                    end
                    if (p2_hs) begin
                        if (bus.p2_move != 2'b11) begin
                            p2_mv_d   = bus.p2_move;
                            p2_have_d = 1'b1;
                        end else begin
                            bad_d[1] = 1'b1;
                        end
                    end
                    if (p1_have_d && p2_have_d) begin
                        state_d = S_JUDGE;
                        first_d = 1'b1;
`ifdef SPS_JUDGE_TIMEOUT_EN
                        tmo_d   = '0;
`endif
                    end
                end
                S_JUDGE: begin
                    if (bus.jdg_done) begin
                        res_d   = bus.jdg_result;
                        state_d = S_UPDATE;
                    end
`ifdef SPS_JUDGE_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_d  = S_OVER;
                        over_d   = 1'b1;
                        winner_d = 2'b11;
                        err_d    = 1'b1;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
`endif
                end
                S_UPDATE: begin
                    round_d  = round_q + 4'd1;
                    score1_d = score1_q + SCORE_W'(res_q == 2'b01);
                    score2_d = score2_q + SCORE_W'(res_q == 2'b10);
                    if (score1_d == WIN_T) begin
                        state_d  = S_OVER;
                        over_d   = 1'b1;
                        winner_d = 2'b01;
                    end else if (score2_d == WIN_T) begin
                        state_d  = S_OVER;
                        over_d   = 1'b1;
                        winner_d = 2'b10;
                    end else if (round_d == MAX_R) begin
                        state_d  = S_OVER;
                        over_d   = 1'b1;
                        winner_d = (score1_d > score2_d) ? 2'b01 :
                                   (score2_d > score1_d) ? 2'b10 : 2'b00;
                    end else begin
                        state_d   = S_COLLECT;
                        p1_mv_d   = 2'b00;
                        p2_mv_d   = 2'b00;
                        p1_have_d = 1'b0;
                        p2_have_d = 1'b0;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // All state holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            p1_mv_q   <= 2'b00;
            p2_mv_q   <= 2'b00;
            p1_have_q <= 1'b0;
            p2_have_q <= 1'b0;
            res_q     <= 2'b00;
            score1_q  <= '0;
            score2_q  <= '0;
            round_q   <= '0;
            over_q    <= 1'b0;
            winner_q  <= 2'b00;
            bad_q     <= 2'b00;
            first_q   <= 1'b0;
`ifdef SPS_JUDGE_TIMEOUT_EN
            tmo_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else if (bus.ena) begin
            state_q   <= state_d;
            p1_mv_q   <= p1_mv_d;
            p2_mv_q   <= p2_mv_d;
            p1_have_q <= p1_have_d;
            p2_have_q <= p2_have_d;
            res_q     <= res_d;
            score1_q  <= score1_d;
            score2_q  <= score2_d;
            round_q   <= round_d;
            over_q    <= over_d;
            winner_q  <= winner_d;
            bad_q     <= bad_d;
            first_q   <= first_d;
`ifdef SPS_JUDGE_TIMEOUT_EN
            tmo_q     <= tmo_d;
            err_q     <= err_d;
`endif
        end
    end

    assign bus.p1_ready     = p1_rdy;
    assign bus.p2_ready     = p2_rdy;
    assign bus.jdg_start    = bus.ena && first_q && (state_q == S_JUDGE);
    assign bus.jdg_p1       = p1_mv_q;
    assign bus.jdg_p2       = p2_mv_q;
    assign bus.score1       = score1_q;
    assign bus.score2       = score2_q;
    assign bus.round_cnt    = round_q;
    assign bus.match_over   = over_q;
    assign bus.match_winner = winner_q;
    assign bus.bad_move     = bad_q & {2{bus.ena}};
`ifdef SPS_JUDGE_TIMEOUT_EN
    assign bus.err          = err_q;
`else
    assign bus.err          = 1'b0;
`endif

endmodule

// File: tb/tb_sps_match_ctrl.sv
// Directed bench for sps_match_ctrl: a match-level score model checked every cycle,
// plus literal expectations for handshakes, judge launch and end-of-match results.
module tb_sps_match_ctrl;
    localparam int WIN  = 2;
    localparam int MAXR = 9;
    localparam int SW   = 4;
    localparam int TMO  = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    sps_match_ctrl_if #(.SCORE_W(SW)) bus ();

    sps_match_ctrl #(
        .WIN_TARGET (WIN),
        .MAX_ROUNDS (MAXR),
        .SCORE_W    (SW),
        .JDG_TIMEOUT(TMO)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_s1, exp_s2, exp_rnd, exp_win;
    bit exp_over, exp_err;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_s1   = 0;
        exp_s2   = 0;
        exp_rnd  = 0;
        exp_win  = 0;
        exp_over = 1'b0;
        exp_err  = 1'b0;
    endtask

    // Score bookkeeping straight from the match rules.
    task automatic model_round(input logic [1:0] res);
        exp_rnd++;
        if (res == 2'b01) exp_s1++;
        if (res == 2'b10) exp_s2++;
        if (exp_s1 == WIN) begin
            exp_over = 1'b1;
            exp_win  = 1;
        end else if (exp_s2 == WIN) begin
            exp_over = 1'b1;
            exp_win  = 2;
        end else if (exp_rnd == MAXR) begin
            exp_over = 1'b1;
            exp_win  = (exp_s1 > exp_s2) ? 1 : (exp_s2 > exp_s1) ? 2 : 0;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_score1", int'(bus.score1), exp_s1);
            chk("mon_score2", int'(bus.score2), exp_s2);
            chk("mon_round_cnt", int'(bus.round_cnt), exp_rnd);
            chk("mon_match_over", int'(bus.match_over), int'(exp_over));
            chk("mon_match_winner", int'(bus.match_winner), exp_win);
            chk("mon_err", int'(bus.err), int'(exp_err));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_p1_ready"}, int'(bus.p1_ready), 0);
        chk({tag, "_p2_ready"}, int'(bus.p2_ready), 0);
        chk({tag, "_jdg_start"}, int'(bus.jdg_start), 0);
        chk({tag, "_jdg_p1"}, int'(bus.jdg_p1), 0);
        chk({tag, "_jdg_p2"}, int'(bus.jdg_p2), 0);
        chk({tag, "_score1"}, int'(bus.score1), 0);
        chk({tag, "_score2"}, int'(bus.score2), 0);
        chk({tag, "_round_cnt"}, int'(bus.round_cnt), 0);
        chk({tag, "_match_over"}, int'(bus.match_over), 0);
        chk({tag, "_match_winner"}, int'(bus.match_winner), 0);
        chk({tag, "_bad_move"}, int'(bus.bad_move), 0);
        chk({tag, "_err"}, int'(bus.err), 0);
    endtask

    task automatic start_match();
        bus.new_match = 1'b1;
        tick();
        bus.new_match = 1'b0;
        model_clear();
        chk("new_match_ready", int'({bus.p1_ready, bus.p2_ready}), 3);
    endtask

    task automatic hand(input bit v1, input logic [1:0] m1, input bit v2, input logic [1:0] m2);
        bus.p1_valid = v1;
        bus.p1_move  = m1;
        bus.p2_valid = v2;
        bus.p2_move  = m2;
        tick();
        bus.p1_valid = 1'b0;
        bus.p2_valid = 1'b0;
    endtask

    // Entered in the first JUDGE cycle; the judge answers after lat extra cycles.
    task automatic judge(input logic [1:0] res, input int lat, input logic [1:0] e1, input logic [1:0] e2);
        chk("jdg_start_first", int'(bus.jdg_start), 1);
        chk("jdg_p1", int'(bus.jdg_p1), int'(e1));
        chk("jdg_p2", int'(bus.jdg_p2), int'(e2));
        chk("ready_in_judge", int'({bus.p1_ready, bus.p2_ready}), 0);
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("jdg_start_once", int'(bus.jdg_start), 0);
            chk("jdg_p1_hold", int'(bus.jdg_p1), int'(e1));
            chk("jdg_p2_hold", int'(bus.jdg_p2), int'(e2));
        end
        bus.jdg_done   = 1'b1;
        bus.jdg_result = res;
        tick();
        bus.jdg_done = 1'b0;
        chk("ready_in_update", int'({bus.p1_ready, bus.p2_ready}), 0);
        tick();
        model_round(res);
        chk("ready_after_round", int'({bus.p1_ready, bus.p2_ready}), exp_over ? 0 : 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: still running at %0t, limit 200000", $time);
        $fatal(1);
    end

    initial begin
        bus.ena        = 1'b1;
        bus.new_match  = 1'b0;
        bus.p1_move    = 2'b00;
        bus.p1_valid   = 1'b0;
        bus.p2_move    = 2'b00;
        bus.p2_valid   = 1'b0;
        bus.jdg_done   = 1'b0;
        bus.jdg_result = 2'b00;
        model_clear();
        repeat (2) tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        chk("idle_ready", int'({bus.p1_ready, bus.p2_ready}), 0);

        // new_match ignored while disabled
        bus.ena       = 1'b0;
        bus.new_match = 1'b1;
        tick();
        bus.new_match = 1'b0;
        bus.ena       = 1'b1;
        #1;
        chk("ena_low_new_match_ignored", int'(bus.p1_ready), 0);
        tick();

        // Match 1: P1 wins 01, 00, 01
        start_match();
        hand(1'b1, 2'b00, 1'b1, 2'b10);
        judge(2'b01, 0, 2'b00, 2'b10);
        chk("m1_score1_r1", int'(bus.score1), 1);
        chk("m1_round_r1", int'(bus.round_cnt), 1);
        hand(1'b1, 2'b11, 1'b0, 2'b00);
        chk("bad_move_p1", int'(bus.bad_move), 1);
        chk("bad_p1_ready_stays", int'(bus.p1_ready), 1);
        hand(1'b1, 2'b01, 1'b0, 2'b00);
        chk("bad_move_clears", int'(bus.bad_move), 0);
        chk("p1_latched_ready", int'({bus.p1_ready, bus.p2_ready}), 1);
        tick();
        tick();
        chk("waiting_p2_ready", int'(bus.p2_ready), 1);
        chk("waiting_no_start", int'(bus.jdg_start), 0);
        hand(1'b0, 2'b00, 1'b1, 2'b00);
        judge(2'b00, 1, 2'b01, 2'b00);
        hand(1'b1, 2'b10, 1'b1, 2'b01);
        judge(2'b01, 2, 2'b10, 2'b01);
        chk("m1_over", int'(bus.match_over), 1);
        chk("m1_winner", int'(bus.match_winner), 1);
        chk("m1_score1", int'(bus.score1), 2);
        chk("m1_score2", int'(bus.score2), 0);
        chk("m1_rounds", int'(bus.round_cnt), 3);
        hand(1'b1, 2'b00, 1'b1, 2'b00);
        chk("over_no_start", int'(bus.jdg_start), 0);
        chk("over_no_ready", int'({bus.p1_ready, bus.p2_ready}), 0);

        // Match 2: nine ties
        start_match();
        for (int i = 0; i < 9; i++) begin
            hand(1'b1, 2'(i % 3), 1'b1, 2'(i % 3));
            judge(2'b00, i % 3, 2'(i % 3), 2'(i % 3));
        end
        chk("m2_rounds", int'(bus.round_cnt), 9);
        chk("m2_over", int'(bus.match_over), 1);
        chk("m2_winner", int'(bus.match_winner), 0);

        // Match 3: round cap decides on score, invalid result counts as a round
        start_match();
        hand(1'b1, 2'b11, 1'b1, 2'b11);
        chk("bad_move_both", int'(bus.bad_move), 3);
        hand(1'b0, 2'b00, 1'b1, 2'b11);
        chk("bad_move_p2", int'(bus.bad_move), 2);
        hand(1'b1, 2'b00, 1'b1, 2'b01);
        judge(2'b10, 0, 2'b00, 2'b01);
        hand(1'b1, 2'b01, 1'b1, 2'b01);
        judge(2'b11, 1, 2'b01, 2'b01);
        for (int i = 0; i < 7; i++) begin
            hand(1'b1, 2'b10, 1'b1, 2'b10);
            judge(2'b00, 0, 2'b10, 2'b10);
        end
        chk("m3_rounds", int'(bus.round_cnt), 9);
        chk("m3_score2", int'(bus.score2), 1);
        chk("m3_winner", int'(bus.match_winner), 2);

        // Match 4: P2 reaches the target
        start_match();
        hand(1'b1, 2'b00, 1'b1, 2'b01);
        judge(2'b10, 0, 2'b00, 2'b01);
        hand(1'b1, 2'b10, 1'b1, 2'b00);
        judge(2'b10, 3, 2'b10, 2'b00);
        chk("m4_winner", int'(bus.match_winner), 2);
        chk("m4_rounds", int'(bus.round_cnt), 2);

        // new_match coinciding with jdg_done drops the result
        start_match();
        hand(1'b1, 2'b00, 1'b1, 2'b01);
        bus.jdg_done   = 1'b1;
        bus.jdg_result = 2'b10;
        bus.new_match  = 1'b1;
        tick();
        bus.jdg_done  = 1'b0;
        bus.new_match = 1'b0;
        model_clear();
        chk("nm_drop_ready", int'({bus.p1_ready, bus.p2_ready}), 3);
        chk("nm_drop_score2", int'(bus.score2), 0);
        tick();
        chk("nm_drop_score2_later", int'(bus.score2), 0);
        hand(1'b1, 2'b01, 1'b1, 2'b00);
        judge(2'b01, 0, 2'b01, 2'b00);
        chk("nm_next_score1", int'(bus.score1), 1);

        // Reset in the middle of JUDGE
        hand(1'b1, 2'b10, 1'b1, 2'b00);
        chk("pre_reset_start", int'(bus.jdg_start), 1);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk_all_zero("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_idle", int'({bus.p1_ready, bus.p2_ready}), 0);

`ifdef SPS_JUDGE_TIMEOUT_EN
        start_match();
        hand(1'b1, 2'b00, 1'b1, 2'b00);
        repeat (TMO - 1) tick();
        chk("tmo_not_yet", int'(bus.match_over), 0);
        tick();
        exp_over = 1'b1;
        exp_err  = 1'b1;
        exp_win  = 3;
        chk("tmo_err", int'(bus.err), 1);
        chk("tmo_winner", int'(bus.match_winner), 3);
        chk("tmo_over", int'(bus.match_over), 1);
        start_match();
        chk("tmo_err_cleared", int'(bus.err), 0);
`else
        start_match();
        hand(1'b1, 2'b00, 1'b1, 2'b10);
        repeat (40) tick();
        chk("wait_no_over", int'(bus.match_over), 0);
        chk("wait_no_err", int'(bus.err), 0);
        bus.jdg_done   = 1'b1;
        bus.jdg_result = 2'b01;
        tick();
        bus.jdg_done = 1'b0;
        tick();
        model_round(2'b01);
        chk("late_judge_score1", int'(bus.score1), 1);
`endif
        tick();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
